// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - registered round-robin bus arbiter with grant locking, wired-OR mode and conflict count
module bus_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int N_SRC      = 8,
  parameter int SRC_W      = 4,
  parameter int OR_MODE    = 0,
  parameter int MAX_LOCK   = 0,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_SRC-1:0]            req,
  input  logic [N_SRC-1:0]            lock,
  input  logic [N_SRC*WORD_WIDTH-1:0] src_data,
  output logic [WORD_WIDTH-1:0]       bus_data,
  output logic                        bus_valid,
  output logic [N_SRC-1:0]            grant,
  output logic [SRC_W-1:0]            bus_src,
  output logic                        conflict,
  output logic [CNT_W-1:0]            conflict_cnt
);

  // Last locked cycle index: a hold is allowed only while lock_cnt is below this.
  localparam logic [31:0] LOCK_LIM = (MAX_LOCK > 0) ? 32'(MAX_LOCK - 1) : 32'd0;

  logic [WORD_WIDTH-1:0] bus_data_q, bus_data_d;
  logic                  bus_valid_q, bus_valid_d;
  logic [N_SRC-1:0]      grant_q, grant_d;
  logic [SRC_W-1:0]      bus_src_q, bus_src_d;
  logic                  conflict_q, conflict_d;
  logic [CNT_W-1:0]      conflict_cnt_q, conflict_cnt_d;
  logic [SRC_W-1:0]      last_owner_q, last_owner_d;
  logic [31:0]           lock_cnt_q, lock_cnt_d;

  int   n_req;
  int   owner;
  int   idx;
  int   win;
  logic found;
  logic hold;

  // Next-state: conflict accounting, then either wired-OR combine or hold / round-robin / idle.
  always_comb begin
    bus_data_d     = '0;
    bus_valid_d    = 1'b0;
    grant_d        = '0;
    bus_src_d      = '0;
    last_owner_d   = last_owner_q;
    lock_cnt_d     = '0;
    n_req          = 0;
    owner          = int'(bus_src_q);
    idx            = 0;
    win            = 0;
    found          = 1'b0;

    for (int i = 0; i < N_SRC; i++) begin
      if (req[i]) n_req = n_req + 1;
    end
    conflict_d     = (n_req > 1);
    conflict_cnt_d = conflict_cnt_q;
    if (conflict_d && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end

    // Only the current owner's lock counts; a lock from anyone else is ignored.
    hold = bus_valid_q && req[owner] && lock[owner] &&
           ((MAX_LOCK == 0) || (lock_cnt_q < LOCK_LIM));

    if (OR_MODE != 0) begin
      // Descending scan so the last assignment leaves the lowest requesting index.
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (req[i]) begin
          bus_data_d = bus_data_d | src_data[i*WORD_WIDTH +: WORD_WIDTH];
          bus_src_d  = SRC_W'(i);
        end
      end
      grant_d     = req;
      bus_valid_d = |req;
    end else if (hold) begin
      grant_d     = grant_q;
      bus_src_d   = bus_src_q;
      bus_valid_d = 1'b1;
      bus_data_d  = src_data[owner*WORD_WIDTH +: WORD_WIDTH];
      lock_cnt_d  = lock_cnt_q + 32'd1;
    end else begin
      // Scan from farthest to nearest after last_owner; the nearest requester overwrites last.
      for (int k = N_SRC; k >= 1; k--) begin
        idx = (int'(last_owner_q) + k) % N_SRC;
        if (req[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
      if (found) begin
        grant_d[win] = 1'b1;
        bus_src_d    = SRC_W'(win);
        bus_valid_d  = 1'b1;
        bus_data_d   = src_data[win*WORD_WIDTH +: WORD_WIDTH];
        last_owner_d = SRC_W'(win);
      end
    end
  end

  // State and output registers; reset wins over any held lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_data_q     <= '0;
      bus_valid_q    <= 1'b0;
      grant_q        <= '0;
      bus_src_q      <= '0;
      conflict_q     <= 1'b0;
      conflict_cnt_q <= '0;
      last_owner_q   <= SRC_W'(N_SRC - 1);
      lock_cnt_q     <= '0;
    end else begin
      bus_data_q     <= bus_data_d;
      bus_valid_q    <= bus_valid_d;
      grant_q        <= grant_d;
      bus_src_q      <= bus_src_d;
      conflict_q     <= conflict_d;
      conflict_cnt_q <= conflict_cnt_d;
      last_owner_q   <= last_owner_d;
      lock_cnt_q     <= lock_cnt_d;
    end
  end

  assign bus_data     = bus_data_q;
  assign bus_valid    = bus_valid_q;
  assign grant        = grant_q;
  assign bus_src      = bus_src_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter in locked, unlimited-lock and wired-OR configurations
module tb_bus_arbiter;
  localparam int NS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [3:0]    req = '0;
  logic [3:0]    lock = '0;
  logic [127:0]  src_data = '0;

  logic [31:0] a_data, b_data, c_data;
  logic        a_valid, b_valid, c_valid;
  logic [3:0]  a_grant, b_grant, c_grant;
  logic [1:0]  a_src, b_src, c_src;
  logic        a_conf, b_conf, c_conf;
  logic [2:0]  a_cnt;
  logic [15:0] b_cnt, c_cnt;

  bus_arbiter #(.WORD_WIDTH(32), .N_SRC(4), .SRC_W(2), .OR_MODE(0), .MAX_LOCK(3), .CNT_W(3)) dut_a (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .src_data(src_data),
    .bus_data(a_data), .bus_valid(a_valid), .grant(a_grant), .bus_src(a_src),
    .conflict(a_conf), .conflict_cnt(a_cnt));

  bus_arbiter #(.WORD_WIDTH(32), .N_SRC(4), .SRC_W(2), .OR_MODE(0), .MAX_LOCK(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .src_data(src_data),
    .bus_data(b_data), .bus_valid(b_valid), .grant(b_grant), .bus_src(b_src),
    .conflict(b_conf), .conflict_cnt(b_cnt));

  bus_arbiter #(.WORD_WIDTH(32), .N_SRC(4), .SRC_W(2), .OR_MODE(1), .MAX_LOCK(0), .CNT_W(16)) dut_c (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .src_data(src_data),
    .bus_data(c_data), .bus_valid(c_valid), .grant(c_grant), .bus_src(c_src),
    .conflict(c_conf), .conflict_cnt(c_cnt));

  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic [3:0]  grant;
    logic [1:0]  src;
    logic        conflict;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    int owner;
    int last;
    int lk;
    int cnt;
  } mdl_t;

  exp_t qa[$], qb[$], qc[$];
  mdl_t ma = '{owner: -1, last: NS - 1, lk: 0, cnt: 0};
  mdl_t mb = '{owner: -1, last: NS - 1, lk: 0, cnt: 0};
  int   c_count = 0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  function automatic logic [31:0] word_of(input logic [127:0] d, input int i);
    return d[i*32 +: 32];
  endfunction

  function automatic logic [127:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Arbitrated reference: owner=-1 means idle; hold while locked within budget, else rotate.
  task automatic arb_model(input int max_lock, input int cnt_w, inout mdl_t m, output exp_t e);
    int cmax;
    cmax = (1 << cnt_w) - 1;
    e = '{data: '0, valid: 1'b0, grant: '0, src: '0, conflict: 1'b0, cnt: '0};
    if (reset) begin
      m = '{owner: -1, last: NS - 1, lk: 0, cnt: 0};
      return;
    end
    if ($countones(req) > 1) begin
      e.conflict = 1'b1;
      if (m.cnt < cmax) m.cnt++;
    end
    if (m.owner >= 0 && req[m.owner] && lock[m.owner] && (max_lock == 0 || m.lk < max_lock - 1)) begin
      m.lk++;
    end else begin
      m.owner = -1;
      m.lk = 0;
      for (int k = 1; k <= NS && m.owner < 0; k++) begin
        if (req[(m.last + k) % NS]) m.owner = (m.last + k) % NS;
      end
      if (m.owner >= 0) m.last = m.owner;
    end
    e.cnt = m.cnt[15:0];
    if (m.owner >= 0) begin
      e.valid = 1'b1;
      e.grant = 4'(1 << m.owner);
      e.src   = m.owner[1:0];
      e.data  = word_of(src_data, m.owner);
    end
  endtask

  // Wired-OR reference: every requester's word ORed together, no ownership.
  task automatic or_model(output exp_t e);
    e = '{data: '0, valid: 1'b0, grant: '0, src: '0, conflict: 1'b0, cnt: '0};
    if (reset) begin
      c_count = 0;
      return;
    end
    if ($countones(req) > 1) begin
      e.conflict = 1'b1;
      if (c_count < 65535) c_count++;
    end
    e.cnt   = c_count[15:0];
    e.grant = req;
    e.valid = |req;
    for (int i = NS - 1; i >= 0; i--) begin
      if (req[i]) begin
        e.data = e.data | word_of(src_data, i);
        e.src  = i[1:0];
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk, input logic [127:0] d);
    exp_t e;
    @(negedge clk);
    reset = r;
    req = rq;
    lock = lk;
    src_data = d;
    arb_model(3, 3, ma, e);
    qa.push_back(e);
    arb_model(0, 16, mb, e);
    qb.push_back(e);
    or_model(e);
    qc.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: pops one expectation per DUT after each edge and compares every output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a.data", a_data, e.data);
        check("a.valid", 32'(a_valid), 32'(e.valid));
        check("a.grant", 32'(a_grant), 32'(e.grant));
        check("a.src", 32'(a_src), 32'(e.src));
        check("a.conflict", 32'(a_conf), 32'(e.conflict));
        check("a.cnt", 32'(a_cnt), 32'(e.cnt));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b.data", b_data, e.data);
        check("b.valid", 32'(b_valid), 32'(e.valid));
        check("b.grant", 32'(b_grant), 32'(e.grant));
        check("b.src", 32'(b_src), 32'(e.src));
        check("b.conflict", 32'(b_conf), 32'(e.conflict));
        check("b.cnt", 32'(b_cnt), 32'(e.cnt));
      end
      if (qc.size() > 0) begin
        e = qc.pop_front();
        check("c.data", c_data, e.data);
        check("c.valid", 32'(c_valid), 32'(e.valid));
        check("c.grant", 32'(c_grant), 32'(e.grant));
        check("c.src", 32'(c_src), 32'(e.src));
        check("c.conflict", 32'(c_conf), 32'(e.conflict));
        check("c.cnt", 32'(c_cnt), 32'(e.cnt));
      end
    end
  end

  // Driver: directed scenarios first, then randomized traffic with sticky requests and locks.
  initial begin
    logic [127:0] da;
    logic [3:0]   rq;
    logic [3:0]   lk;
    logic         r;
    da = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    rq = '0;

    repeat (2) step(1'b1, 4'h0, 4'h0, rnd_data());
    repeat (2) step(1'b0, 4'h0, 4'h0, rnd_data());
    step(1'b0, 4'h5, 4'h0, rnd_data());

    step(1'b1, 4'h0, 4'h0, rnd_data());
    repeat (8) step(1'b0, 4'hF, 4'h0, da);

    step(1'b1, 4'h0, 4'h0, rnd_data());
    repeat (10) step(1'b0, 4'h6, 4'h2, rnd_data());

    step(1'b1, 4'h0, 4'h0, rnd_data());
    repeat (5) step(1'b0, 4'h9, 4'h1, rnd_data());
    step(1'b0, 4'h8, 4'h1, rnd_data());
    step(1'b0, 4'h0, 4'h0, rnd_data());

    step(1'b1, 4'h0, 4'h0, rnd_data());
    step(1'b0, 4'h3, 4'h0, {64'h0, 32'h0000_0F00, 32'h0000_00F0});
    step(1'b0, 4'h0, 4'h0, rnd_data());

    repeat (2) step(1'b0, 4'h2, 4'h2, rnd_data());
    step(1'b1, 4'h2, 4'h2, rnd_data());
    step(1'b0, 4'hF, 4'h0, rnd_data());

    repeat (600) begin
      r  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      lk = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
      step(r, rq, lk, rnd_data());
    end
    step(1'b0, 4'h0, 4'h0, rnd_data());

    @(posedge clk);
    #2;
    total++;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d expected=0", qa.size() + qb.size() + qc.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised, registered successor to the CPU's wired-OR data bus.
- Takes N_SRC sources (ALU, RAM, IO, regs, CP, IND, offset, ...), each with a request line and a data word.
- Round-robin arbitration selects one source per cycle and drives a single registered bus word to all sinks.
- Supports grant locking for multi-cycle transfers, a legacy wired-OR mode, and conflict accounting for debug.

Parameters:
- WORD_WIDTH, 32, width of each source word and of the bus.
- N_SRC, 8, number of bus sources (2..16).
- SRC_W, 4, width of the source index; must satisfy 2^SRC_W >= N_SRC.
- OR_MODE, 0, 1 = legacy wired-OR combine of all requesting sources with no arbitration.
- MAX_LOCK, 0, maximum consecutive locked cycles before forced release; 0 = unlimited.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N_SRC  per-source bus request.
- lock  input  N_SRC  per-source hold request; only meaningful for the current owner.
- src_data  input  N_SRC*WORD_WIDTH  source words, flattened; source i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
- bus_data  output  WORD_WIDTH  registered bus word.
- bus_valid  output  1  bus_data holds a granted word this cycle.
- grant  output  N_SRC  registered one-hot owner; in OR_MODE, a copy of the registered req.
- bus_src  output  SRC_W  index of the owner; 0 when idle.
- conflict  output  1  registered; high for one cycle when more than one req was high in the previous cycle.
- conflict_cnt  output  CNT_W  saturating count of cycles with conflict.

Behaviour:
- Reset (clk edge with reset=1):
  - bus_data=0, bus_valid=0, grant=0, bus_src=0, conflict=0, conflict_cnt=0.
  - RR pointer last_owner=N_SRC-1, so source 0 has top priority first.
  - lock_cnt=0.
  - Reset overrides everything, including a held lock.
- Latency: exactly 1 cycle. req and src_data sampled at edge t appear on bus_data/grant after edge t.
- The winner's data is captured in the same cycle as its req. A source must present valid data whenever req is high.
- Arbitration (OR_MODE=0), evaluated each cycle in this order:
  1. Hold: if the current owner o has req[o]=1 and lock[o]=1, and (MAX_LOCK=0 or lock_cnt<MAX_LOCK-1), o keeps the grant and lock_cnt increments.
  2. Round-robin: otherwise the winner is the first i with req[i]=1, scanning last_owner+1, last_owner+2, ... modulo N_SRC. The owner being released is considered last. last_owner updates to the winner and lock_cnt clears to 0.
  3. Idle: if no req, then grant=0, bus_valid=0, bus_data=0, bus_src=0. last_owner is unchanged and lock_cnt clears.
- Forced release: when lock_cnt reaches MAX_LOCK-1 and the owner still locks, the next cycle arbitrates round-robin. If the owner is the only requester, it wins again with lock_cnt=0.
- Owner dropping req releases immediately, regardless of lock.
- lock from a non-owner is ignored.
- OR_MODE=1:
  - bus_data = bitwise OR of src_data[i] over all i with req[i]=1, registered.
  - grant = req registered; bus_valid = |req; bus_src = lowest set index.
  - lock and MAX_LOCK are ignored.
- Non-requesting sources' data never reaches the bus in either mode. Sinks may OR-combine buses safely because an idle bus is 0.
- Conflict accounting:
  - conflict <= (popcount(req) > 1), in both modes.
  - conflict_cnt increments on each such cycle and saturates at 2^CNT_W-1. It does not wrap.
- Widths: src_data indexing is exact. bus_src is zero-extended to SRC_W.

Test Plan:
- Reset and idle: reset=1 for 2 cycles, then req=0 -> all outputs 0. The first grant after req=8'h05 goes to source 0 (grant=8'h01, bus_src=0).
- Round-robin fairness: N_SRC=4, req=4'hF held 8 cycles, src i data=32'hA0+i -> grant sequence 1,2,4,8,1,2,4,8. bus_data follows A0..A3. conflict=1 every cycle, conflict_cnt=8.
- Lock and forced release: MAX_LOCK=3, src1 req+lock, src2 req, both held -> src1 owns 3 cycles, src2 1 cycle, then src1 3 cycles. With MAX_LOCK=0, src1 owns indefinitely.
- Owner drop: src0 locked owner drops req at cycle 5 while src3 requests -> cycle 6 grant=4'h8, bus_data=src3 word. No idle gap.
- OR_MODE=1: req=4'h3, src0=32'h0000_00F0, src1=32'h0000_0F00 -> bus_data=32'h0000_0FF0, grant=4'h3, conflict=1. With req=0 -> bus_data=0, bus_valid=0.
- Saturation and mid-lock reset: CNT_W=2 with 5 conflict cycles -> conflict_cnt=3. reset=1 during a lock -> next cycle grant=0 and round-robin restarts at source 0.
